// File: rtl/bus_arbiter_3.sv
// Round-robin arbiter that multiplexes three WIDTH-bit requesters onto one registered bus.
// Each tenure is limited to MAX_HOLD cycles, and every release is followed by one idle turnaround cycle.
module bus_arbiter_3 #(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  output logic [2:0]       gnt,
  output logic [1:0]       select,
  output logic [WIDTH-1:0] bus_data,
  output logic             bus_valid,
  output logic             busy
);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [7:0]       hold_q, hold_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;

  logic [1:0]       winner;
  logic             own_req;
  logic [WIDTH-1:0] src_data;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    rr_next = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // The requester just served is scanned last, so it is lowest priority.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] c1, c2;
    c1 = rr_next(last);
    c2 = rr_next(c1);
    if (r[c1])      rr_pick = c1;
    else if (r[c2]) rr_pick = c2;
    else            rr_pick = rr_next(c2);
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    case (idx)
      2'd0:    onehot3 = 3'b001;
      2'd1:    onehot3 = 3'b010;
      default: onehot3 = 3'b100;
    endcase
  endfunction

  assign winner  = rr_pick(req, last_q);
  assign own_req = req[sel_q];

  always_comb begin
    case (sel_q)
      2'd0:    src_data = D0;
      2'd1:    src_data = D1;
      default: src_data = D2;
    endcase
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    hold_d  = hold_q;
    data_d  = data_q;
    vld_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_GRANT;
          gnt_d   = onehot3(winner);
          sel_d   = winner;
          hold_d  = 8'd0;
        end
      end
      ST_GRANT: begin
        if (own_req) begin
          data_d = src_data;
          vld_d  = 1'b1;
        end
        // A forced release on the last allowed cycle still completes its transfer.
        if (!own_req || (hold_q == HOLD_LAST)) begin
          state_d = ST_IDLE;
          gnt_d   = 3'b000;
          sel_d   = 2'd0;
          last_d  = sel_q;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 3'b000;
        sel_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 3'b000;
      sel_q   <= 2'd0;
      last_q  <= 2'd2;
      hold_q  <= 8'd0;
      data_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
    end
  end

  assign gnt       = gnt_q;
  assign select    = sel_q;
  assign bus_data  = data_q;
  assign bus_valid = vld_q;
  assign busy      = (state_q == ST_GRANT);

endmodule

// File: tb/tb_bus_arbiter_3.sv
// Scoreboard bench for bus_arbiter_3 (MAX_HOLD=4): directed request patterns push expected
// grants, tenure lengths and bus words; a negedge monitor pops and compares them.
module tb_bus_arbiter_3;
  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [2:0]  req;
  logic [15:0] D0, D1, D2;
  logic [2:0]  gnt;
  logic [1:0]  select;
  logic [15:0] bus_data;
  logic        bus_valid;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0]  exp_gnt_q[$];
  int          exp_len_q[$];
  logic [15:0] exp_data_q[$];

  logic [2:0]  prev_gnt = 3'b000;
  int          run = 0;

  bus_arbiter_3 #(.WIDTH(16), .MAX_HOLD(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .req(req), .D0(D0), .D1(D1), .D2(D2),
    .gnt(gnt), .select(select), .bus_data(bus_data), .bus_valid(bus_valid), .busy(busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic underflow(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: DUT output with no expected entry at %0t", name, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic expect_tenure(input logic [2:0] g, input int len, input logic [15:0] d, input int n);
    exp_gnt_q.push_back(g);
    if (len > 0) exp_len_q.push_back(len);
    repeat (n) exp_data_q.push_back(d);
  endtask

  function automatic logic [1:0] enc(input logic [2:0] g);
    case (g)
      3'b010:  enc = 2'd1;
      3'b100:  enc = 2'd2;
      default: enc = 2'd0;
    endcase
  endfunction

  always @(negedge Clk) begin
    if (!Reset_n) begin
      prev_gnt = 3'b000;
      run      = 0;
    end else begin
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("select_legal", 32'(select != 2'b11), 32'd1);
      chk("busy_eq_gnt", 32'(busy), 32'(|gnt));
      if (bus_valid) begin
        if (exp_data_q.size() == 0) underflow("bus_data");
        else chk("bus_data", 32'(bus_data), 32'(exp_data_q.pop_front()));
      end
      if (gnt != 3'b000) begin
        if (prev_gnt == 3'b000) begin
          if (exp_gnt_q.size() == 0) underflow("grant");
          else begin
            logic [2:0] eg;
            eg = exp_gnt_q.pop_front();
            chk("grant", 32'(gnt), 32'(eg));
            chk("grant_select", 32'(select), 32'(enc(eg)));
          end
        end else begin
          chk("gnt_stable", 32'(gnt), 32'(prev_gnt));
        end
        run++;
      end else if (run > 0) begin
        if (exp_len_q.size() == 0) underflow("tenure_len");
        else chk("tenure_len", 32'(run), 32'(exp_len_q.pop_front()));
        run = 0;
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    Reset_n = 1'b0;
    req = 3'b000;
    D0 = 16'h0; D1 = 16'h0; D2 = 16'h0;
    @(posedge Clk); #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_select", 32'(select), 32'd0);
    chk("rst_bus_data", 32'(bus_data), 32'd0);
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick(2);
    Reset_n = 1'b1;
    tick(2);

    // Single requester 1: 3 transfers, released when req drops in grant cycle 4.
    D1 = 16'hBEEF;
    expect_tenure(3'b010, 4, 16'hBEEF, 3);
    req = 3'b010;
    tick(4);
    req = 3'b000;
    tick(3);

    // All requesting after owner 1: order 2,0,1,2, four-cycle forced tenures.
    D0 = 16'hA000; D1 = 16'hA111; D2 = 16'hA222;
    expect_tenure(3'b100, 4, 16'hA222, 4);
    expect_tenure(3'b001, 4, 16'hA000, 4);
    expect_tenure(3'b010, 4, 16'hA111, 4);
    expect_tenure(3'b100, 4, 16'hA222, 4);
    req = 3'b111;
    tick(20);
    req = 3'b000;
    tick(3);

    // Lone requester 0 times out and is re-granted after one idle cycle.
    D0 = 16'hC0C0;
    expect_tenure(3'b001, 4, 16'hC0C0, 4);
    expect_tenure(3'b001, 4, 16'hC0C0, 4);
    req = 3'b001;
    tick(10);
    req = 3'b000;
    tick(3);

    // Owner 0 drops in grant cycle 3 while req2 waits (raised mid-tenure).
    D0 = 16'h5A5A; D2 = 16'h7E7E;
    expect_tenure(3'b001, 3, 16'h5A5A, 2);
    expect_tenure(3'b100, 4, 16'h7E7E, 4);
    req = 3'b001;
    tick(1);
    req = 3'b101;
    tick(2);
    req = 3'b100;
    tick(6);
    req = 3'b000;
    tick(3);

    // req1 falls the same cycle req0 rises: one turnaround cycle, then gnt=001.
    D1 = 16'h1111; D0 = 16'h2222;
    expect_tenure(3'b010, 2, 16'h1111, 1);
    expect_tenure(3'b001, 4, 16'h2222, 4);
    req = 3'b010;
    tick(2);
    req = 3'b001;
    tick(1);
    chk("turnaround_gnt", 32'(gnt), 32'd0);
    tick(1);
    chk("b2b_gnt", 32'(gnt), 32'b001);
    chk("b2b_select", 32'(select), 32'd0);
    tick(4);
    req = 3'b000;
    tick(3);

    // Reset in the middle of a tenure owned by 1; afterwards requester 0 wins first.
    D0 = 16'h3333; D1 = 16'h4444; D2 = 16'h5555;
    expect_tenure(3'b010, 0, 16'h0, 0);
    expect_tenure(3'b001, 4, 16'h3333, 4);
    req = 3'b111;
    tick(2);
    Reset_n = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_select", 32'(select), 32'd0);
    chk("midrst_bus_valid", 32'(bus_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_bus_data", 32'(bus_data), 32'd0);
    tick(1);
    Reset_n = 1'b1;
    tick(5);
    req = 3'b000;
    tick(4);

    chk("gnt_queue_empty", 32'(exp_gnt_q.size()), 32'd0);
    chk("len_queue_empty", 32'(exp_len_q.size()), 32'd0);
    chk("data_queue_empty", 32'(exp_data_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
